// File: rtl/ysyx_22050078_fwd_scoreboard_if.sv
// Bundle of the ID-stage operand/hazard signals exchanged between the pipeline
// (master) and the forwarding/scoreboard unit (slave).
interface ysyx_22050078_fwd_scoreboard_if #(
    parameter int XLEN = 64,
    parameter int RAW  = 5,
    parameter int NFWD = 3
);
    logic [RAW-1:0]       i_rs1_addr;
    logic [RAW-1:0]       i_rs2_addr;
    logic [RAW-1:0]       i_rd_addr;
    logic                 i_rd_wen;
    logic                 i_st_en;
    logic [XLEN-1:0]      i_rf_rs1;
    logic [XLEN-1:0]      i_rf_rs2;
    logic [NFWD-1:0]      i_fwd_vld;
    logic [NFWD-1:0]      i_fwd_rdy;
    logic [NFWD-1:0]      i_fwd_ld;
    logic [NFWD*RAW-1:0]  i_fwd_rd;
    logic [NFWD*XLEN-1:0] i_fwd_data;
    logic                 i_lop_issue;
    logic [RAW-1:0]       i_lop_rd;
    logic                 i_lop_done;
    logic [RAW-1:0]       i_lop_drd;
    logic [XLEN-1:0]      i_lop_data;
    logic [XLEN-1:0]      i_ld_data;
    logic [XLEN-1:0]      i_exu_rs2;
    logic                 i_cnt_clr;
    logic [XLEN-1:0]      o_rs1_data;
    logic [XLEN-1:0]      o_rs2_data;
    logic                 o_stall;
    logic                 o_ldstbp;
    logic [XLEN-1:0]      o_exu_rs2;
    logic                 o_lop_full;
    logic [31:0]          o_stall_cnt;

    modport master (
        output i_rs1_addr, i_rs2_addr, i_rd_addr, i_rd_wen, i_st_en,
               i_rf_rs1, i_rf_rs2, i_fwd_vld, i_fwd_rdy, i_fwd_ld, i_fwd_rd,
               i_fwd_data, i_lop_issue, i_lop_rd, i_lop_done, i_lop_drd,
               i_lop_data, i_ld_data, i_exu_rs2, i_cnt_clr,
        input  o_rs1_data, o_rs2_data, o_stall, o_ldstbp, o_exu_rs2,
               o_lop_full, o_stall_cnt
    );

    modport slave (
        input  i_rs1_addr, i_rs2_addr, i_rd_addr, i_rd_wen, i_st_en,
               i_rf_rs1, i_rf_rs2, i_fwd_vld, i_fwd_rdy, i_fwd_ld, i_fwd_rd,
               i_fwd_data, i_lop_issue, i_lop_rd, i_lop_done, i_lop_drd,
               i_lop_data, i_ld_data, i_exu_rs2, i_cnt_clr,
        output o_rs1_data, o_rs2_data, o_stall, o_ldstbp, o_exu_rs2,
               o_lop_full, o_stall_cnt
    );
endinterface

// File: rtl/ysyx_22050078_fwd_scoreboard.sv
// ID-stage operand forwarding and hazard unit: NFWD in-order bypass sources,
// a register scoreboard for out-of-band multi-cycle ops, an x0 guard, a
// registered load->store data bypass and a saturating stall counter.
//
// Handshake: a multi-cycle op is accepted only in a cycle where i_lop_issue=1
// and o_stall=0 (o_stall acts as !ready); i_lop_done is a one-cycle pulse with
// no back-pressure, and the result on i_lop_data is valid only in that cycle.
module ysyx_22050078_fwd_scoreboard #(
    parameter int XLEN   = 64,
    parameter int RAW    = 5,
    parameter int NFWD   = 3,
    parameter int MAXOUT = 4
) (
    input logic clk,
    input logic rst,
    ysyx_22050078_fwd_scoreboard_if.slave io_bus
);
    localparam int OCW  = $clog2(MAXOUT + 1);
    localparam int NREG = 1 << RAW;

    logic [NREG-1:0] r_pending;
    logic [OCW-1:0]  r_out_cnt;
    logic            r_ldstbp_q;
    logic [31:0]     r_stall_cnt;

    logic [NREG-1:0] w_pend_eff;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;
    logic            w_rs1_nrdy;
    logic            w_rs2_nrdy;
    logic            w_rs1_haz;
    logic            w_rs2_haz;
    logic            w_waw_haz;
    logic            w_ldstbp;
    logic            w_full;
    logic            w_stall;
    logic            w_issue_acc;
    logic            w_done_cnt;
    logic            w_unused_ld;

    // Only the youngest source can feed the load->store bypass.
    assign w_unused_ld = ^io_bus.i_fwd_ld[NFWD-1:1];

    // An op finishing this cycle is no longer a hazard: its data is bypassed.
    always_comb begin
        w_pend_eff = r_pending;
        if (io_bus.i_lop_done) begin
            w_pend_eff[io_bus.i_lop_drd] = 1'b0;
        end
    end

    // Operand select: x0, then youngest matching source, then completing op, then RF.
    always_comb begin
        w_rs1_data = io_bus.i_rf_rs1;
        w_rs2_data = io_bus.i_rf_rs2;
        w_rs1_nrdy = 1'b0;
        w_rs2_nrdy = 1'b0;
        if (io_bus.i_lop_done && io_bus.i_lop_drd == io_bus.i_rs1_addr) begin
            w_rs1_data = io_bus.i_lop_data;
        end
        if (io_bus.i_lop_done && io_bus.i_lop_drd == io_bus.i_rs2_addr) begin
            w_rs2_data = io_bus.i_lop_data;
        end
        // Walk oldest to youngest so the youngest match is the one that sticks.
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (io_bus.i_fwd_vld[i] && io_bus.i_fwd_rd[i*RAW +: RAW] == io_bus.i_rs1_addr) begin
                w_rs1_data = io_bus.i_fwd_data[i*XLEN +: XLEN];
                w_rs1_nrdy = !io_bus.i_fwd_rdy[i];
            end
            if (io_bus.i_fwd_vld[i] && io_bus.i_fwd_rd[i*RAW +: RAW] == io_bus.i_rs2_addr) begin
                w_rs2_data = io_bus.i_fwd_data[i*XLEN +: XLEN];
                w_rs2_nrdy = !io_bus.i_fwd_rdy[i];
            end
        end
        if (io_bus.i_rs1_addr == '0) begin
            w_rs1_data = '0;
            w_rs1_nrdy = 1'b0;
        end
        if (io_bus.i_rs2_addr == '0) begin
            w_rs2_data = '0;
            w_rs2_nrdy = 1'b0;
        end
    end

    // A store whose data comes from a load still in the youngest stage picks it up one stage later.
    assign w_ldstbp = io_bus.i_fwd_ld[0] && io_bus.i_fwd_vld[0] && !io_bus.i_fwd_rdy[0]
                   && io_bus.i_fwd_rd[0 +: RAW] == io_bus.i_rs2_addr
                   && io_bus.i_rs2_addr != '0 && io_bus.i_st_en;

    assign w_rs1_haz   = w_rs1_nrdy || (io_bus.i_rs1_addr != '0 && w_pend_eff[io_bus.i_rs1_addr]);
    assign w_rs2_haz   = !w_ldstbp &&
                         (w_rs2_nrdy || (io_bus.i_rs2_addr != '0 && w_pend_eff[io_bus.i_rs2_addr]));
    assign w_waw_haz   = io_bus.i_rd_wen && io_bus.i_rd_addr != '0 && w_pend_eff[io_bus.i_rd_addr];
    assign w_full      = (r_out_cnt == OCW'(MAXOUT));
    assign w_stall     = w_rs1_haz || w_rs2_haz || w_waw_haz || (io_bus.i_lop_issue && w_full);
    assign w_issue_acc = io_bus.i_lop_issue && !w_stall;
    assign w_done_cnt  = io_bus.i_lop_done && r_out_cnt != '0;

    // Scoreboard: completion clears, accepted issue sets (issue wins on the same rd).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pend_eff;
            if (w_issue_acc && io_bus.i_lop_rd != '0) begin
                r_pending[io_bus.i_lop_rd] <= 1'b1;
            end
        end
    end

    // Outstanding multi-cycle op count; completions at zero are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_cnt <= '0;
        end else if (w_issue_acc && !w_done_cnt) begin
            r_out_cnt <= r_out_cnt + OCW'(1);
        end else if (!w_issue_acc && w_done_cnt) begin
            r_out_cnt <= r_out_cnt - OCW'(1);
        end
    end

    // Remember that the instruction leaving ID took the load->store bypass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ldstbp_q <= 1'b0;
        end else begin
            r_ldstbp_q <= w_ldstbp && !w_stall;
        end
    end

    // Saturating stall-cycle counter; clear has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (io_bus.i_cnt_clr) begin
            r_stall_cnt <= '0;
        end else if (w_stall && r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign io_bus.o_rs1_data  = w_rs1_data;
    assign io_bus.o_rs2_data  = w_rs2_data;
    assign io_bus.o_stall     = w_stall;
    assign io_bus.o_ldstbp    = w_ldstbp;
    assign io_bus.o_exu_rs2   = r_ldstbp_q ? io_bus.i_ld_data : io_bus.i_exu_rs2;
    assign io_bus.o_lop_full  = w_full;
    assign io_bus.o_stall_cnt = r_stall_cnt;
endmodule
